// File: rtl/ddr_rd_stream_if.sv
// rtl/ddr_rd_stream_if.sv - request, MCB port-2 and output-stream signal bundle for ddr_rd_stream
// master is the read engine's side of the bundle; slave is the surrounding MCB/consumer side.
interface ddr_rd_stream_if;
   logic        c3_calib_done;

   logic        req_valid;
   logic        req_ready;
   logic [29:0] req_addr;
   logic [15:0] req_words;

   logic        c3_p2_cmd_en;
   logic [2:0]  c3_p2_cmd_instr;
   logic [5:0]  c3_p2_cmd_bl;
   logic [29:0] c3_p2_cmd_byte_addr;
   logic        c3_p2_cmd_full;

   logic        c3_p2_rd_en;
   logic [31:0] c3_p2_rd_data;
   logic        c3_p2_rd_empty;
   logic        c3_p2_rd_overflow;
   logic        c3_p2_rd_error;

   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;

   logic        done;
   logic        err;

   modport master (
      input  c3_calib_done,
      input  req_valid, req_addr, req_words,
      output req_ready,
      output c3_p2_cmd_en, c3_p2_cmd_instr, c3_p2_cmd_bl, c3_p2_cmd_byte_addr,
      input  c3_p2_cmd_full,
      output c3_p2_rd_en,
      input  c3_p2_rd_data, c3_p2_rd_empty, c3_p2_rd_overflow, c3_p2_rd_error,
      output m_valid, m_data, m_last,
      input  m_ready,
      output done, err
   );

   modport slave (
      output c3_calib_done,
      output req_valid, req_addr, req_words,
      input  req_ready,
      input  c3_p2_cmd_en, c3_p2_cmd_instr, c3_p2_cmd_bl, c3_p2_cmd_byte_addr,
      output c3_p2_cmd_full,
      input  c3_p2_rd_en,
      output c3_p2_rd_data, c3_p2_rd_empty, c3_p2_rd_overflow, c3_p2_rd_error,
      input  m_valid, m_data, m_last,
      output m_ready,
      input  done, err
   );
endinterface

// File: rtl/ddr_rd_stream.sv
// rtl/ddr_rd_stream.sv - MCB port-2 read engine: splits a word count into read bursts and streams the data out
// Commands are credit-limited so the MCB read FIFO is never asked to hold more words than it has room for.
module ddr_rd_stream #(
   parameter int MAX_BURST     = 64,
   parameter int RD_FIFO_DEPTH = 64
) (
   input logic             clk,
   input logic             rst,
   ddr_rd_stream_if.master bus
);
   typedef enum logic [1:0] {
      WAIT_CALIB = 2'd0,
      IDLE       = 2'd1,
      ISSUE      = 2'd2,
      DRAIN      = 2'd3
   } state_t;

   localparam logic [15:0] MAX_BURST_W  = 16'(MAX_BURST);
   localparam logic [7:0]  FIFO_DEPTH_W = 8'(RD_FIFO_DEPTH);
   localparam logic [2:0]  INSTR_READ   = 3'b001;

   state_t      state_q, state_d;
   logic [29:0] cmd_addr_q, cmd_addr_d;
   logic [15:0] cmd_rem_q, cmd_rem_d;
   logic [15:0] rx_rem_q, rx_rem_d;
   logic [6:0]  outstanding_q, outstanding_d;
   logic [31:0] m_data_q, m_data_d;
   logic        m_valid_q, m_valid_d;
   logic        m_last_q, m_last_d;
   logic        err_q, err_d;
   logic        done_q, done_d;

   logic [6:0]  burst;
   logic        credit_ok;
   logic        cmd_issue;
   logic        rd_pop;
   logic        beat_xfer;
   logic        last_xfer;

   // Outstanding counts words commanded but not yet popped, i.e. the MCB FIFO fill level.
   always_comb begin
      burst     = (cmd_rem_q > MAX_BURST_W) ? MAX_BURST_W[6:0] : cmd_rem_q[6:0];
      credit_ok = ({1'b0, outstanding_q} + {1'b0, burst}) <= FIFO_DEPTH_W;
      cmd_issue = (state_q == ISSUE) && !bus.c3_p2_cmd_full && credit_ok;
      rd_pop    = ((state_q == ISSUE) || (state_q == DRAIN)) && !bus.c3_p2_rd_empty &&
                  (rx_rem_q != 16'd0) && (!m_valid_q || bus.m_ready);
      beat_xfer = m_valid_q && bus.m_ready;
      last_xfer = (state_q == DRAIN) && beat_xfer && m_last_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= WAIT_CALIB;
         cmd_addr_q    <= 30'd0;
         cmd_rem_q     <= 16'd0;
         rx_rem_q      <= 16'd0;
         outstanding_q <= 7'd0;
         m_data_q      <= 32'd0;
         m_valid_q     <= 1'b0;
         m_last_q      <= 1'b0;
         err_q         <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_addr_q    <= cmd_addr_d;
         cmd_rem_q     <= cmd_rem_d;
         rx_rem_q      <= rx_rem_d;
         outstanding_q <= outstanding_d;
         m_data_q      <= m_data_d;
         m_valid_q     <= m_valid_d;
         m_last_q      <= m_last_d;
         err_q         <= err_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cmd_addr_d    = cmd_addr_q;
      cmd_rem_d     = cmd_rem_q;
      rx_rem_d      = rx_rem_q;
      outstanding_d = outstanding_q;
      m_data_d      = m_data_q;
      m_valid_d     = m_valid_q;
      m_last_d      = m_last_q;
      err_d         = err_q;
      done_d        = 1'b0;

      case (state_q)
         WAIT_CALIB: begin
            if (bus.c3_calib_done) state_d = IDLE;
         end
         IDLE: begin
            if (bus.req_valid) begin
               cmd_addr_d = {bus.req_addr[29:2], 2'b00};
               cmd_rem_d  = bus.req_words;
               rx_rem_d   = bus.req_words;
               err_d      = 1'b0;
               if (bus.req_words != 16'd0) state_d = ISSUE;
               else                        done_d  = 1'b1;
            end
         end
         ISSUE: begin
            if (cmd_issue) begin
               cmd_addr_d = cmd_addr_q + {21'd0, burst, 2'b00};
               cmd_rem_d  = cmd_rem_q - {9'd0, burst};
               if (cmd_rem_q == {9'd0, burst}) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_xfer) state_d = IDLE;
         end
         default: state_d = WAIT_CALIB;
      endcase

      outstanding_d = outstanding_q + (cmd_issue ? burst : 7'd0) - {6'd0, rd_pop};

      // One-entry output register: a pop refills it in the same cycle the old word leaves.
      if (rd_pop) begin
         m_data_d  = bus.c3_p2_rd_data;
         m_valid_d = 1'b1;
         m_last_d  = (rx_rem_q == 16'd1);
         rx_rem_d  = rx_rem_q - 16'd1;
      end else if (beat_xfer) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end

      if (bus.c3_p2_rd_overflow || bus.c3_p2_rd_error) err_d = 1'b1;
   end

   assign bus.req_ready           = (state_q == IDLE);
   assign bus.c3_p2_cmd_en        = cmd_issue;
   assign bus.c3_p2_cmd_instr     = (state_q == ISSUE) ? INSTR_READ : 3'd0;
   assign bus.c3_p2_cmd_bl        = (state_q == ISSUE) ? 6'(burst - 7'd1) : 6'd0;
   assign bus.c3_p2_cmd_byte_addr = (state_q == ISSUE) ? cmd_addr_q : 30'd0;
   assign bus.c3_p2_rd_en         = rd_pop;
   assign bus.m_valid             = m_valid_q;
   assign bus.m_data              = m_data_q;
   assign bus.m_last              = m_last_q;
   assign bus.done                = done_q || last_xfer;
   assign bus.err                 = err_q;
endmodule

// File: tb/tb_ddr_rd_stream.sv
// tb/tb_ddr_rd_stream.sv - self-checking bench for ddr_rd_stream against an MCB FIFO model and burst-split reference
// Inputs change at negedge, everything is observed at negedge+3/+4, well clear of the posedge.
`timescale 1ns/1ps
module tb_ddr_rd_stream;
   localparam int MAX_BURST = 64;
   localparam int DEPTH     = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   ddr_rd_stream_if bus();

   ddr_rd_stream #(.MAX_BURST(MAX_BURST), .RD_FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] rdq[$];
   logic [35:0] cmd_log[$];
   logic [32:0] beat_log[$];
   int          done_cnt, done_bad, viol_empty, viol_stable, max_fifo;
   int          ready_pct = 100, empty_pct = 0, full_pct = 0;
   bit          full_force = 1'b0, hold_ready = 1'b0, zero_mode = 1'b0;
   logic [31:0] salt;
   logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
   logic [31:0] prev_data = 32'd0;

   function automatic logic [31:0] mem_word(input logic [29:0] a);
      return {a, 2'b00} ^ salt;
   endfunction

   // MCB model: command FIFO with random back-pressure, read FIFO filled by each issued command.
   always @(negedge clk) begin
      bus.c3_p2_cmd_full = full_force || (int'($urandom_range(99, 0)) < full_pct);
      bus.m_ready        = !hold_ready && (int'($urandom_range(99, 0)) < ready_pct);
      bus.c3_p2_rd_empty = (rdq.size() == 0) || (int'($urandom_range(99, 0)) < empty_pct);
      bus.c3_p2_rd_data  = (rdq.size() != 0) ? rdq[0] : $urandom;
      #3;
      if (!rst_n) begin
         rdq.delete();
         prev_valid = 1'b0;
      end else begin
         if (bus.c3_p2_rd_en) begin
            if (bus.c3_p2_rd_empty || rdq.size() == 0) viol_empty++;
            else void'(rdq.pop_front());
         end
         if (bus.c3_p2_cmd_en) begin
            cmd_log.push_back({bus.c3_p2_cmd_bl, bus.c3_p2_cmd_byte_addr});
            for (int i = 0; i <= int'(bus.c3_p2_cmd_bl); i++)
               rdq.push_back(mem_word(bus.c3_p2_cmd_byte_addr + 30'(4 * i)));
            if (rdq.size() > max_fifo) max_fifo = rdq.size();
         end
         if (prev_valid && !prev_ready &&
             (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last)) viol_stable++;
         if (bus.m_valid && bus.m_ready) beat_log.push_back({bus.m_last, bus.m_data});
         if (bus.done) begin
            done_cnt++;
            if (!zero_mode && !(bus.m_valid && bus.m_ready && bus.m_last)) done_bad++;
         end
         prev_valid = bus.m_valid;
         prev_ready = bus.m_ready;
         prev_data  = bus.m_data;
         prev_last  = bus.m_last;
      end
   end

   task automatic step();
      @(negedge clk);
      #4;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_req_ready"}, bus.req_ready, 0);
      check({tag, "_cmd_en"}, bus.c3_p2_cmd_en, 0);
      check({tag, "_cmd_instr"}, bus.c3_p2_cmd_instr, 0);
      check({tag, "_cmd_bl"}, bus.c3_p2_cmd_bl, 0);
      check({tag, "_cmd_addr"}, bus.c3_p2_cmd_byte_addr, 0);
      check({tag, "_rd_en"}, bus.c3_p2_rd_en, 0);
      check({tag, "_m_valid"}, bus.m_valid, 0);
      check({tag, "_m_data"}, bus.m_data, 0);
      check({tag, "_m_last"}, bus.m_last, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_err"}, bus.err, 0);
   endtask

   // Returns at the observation point of the first cycle after the request was accepted.
   task automatic start_xfer(input logic [29:0] a, input logic [15:0] w);
      int n;
      n = 0;
      cmd_log.delete();
      beat_log.delete();
      done_cnt    = 0;
      done_bad    = 0;
      viol_empty  = 0;
      viol_stable = 0;
      max_fifo    = 0;
      while (!bus.req_ready && n < 1000) begin
         step();
         n++;
      end
      check("req_ready_wait", bus.req_ready, 1);
      bus.req_addr  = a;
      bus.req_words = w;
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic finish_xfer(input logic [29:0] a, input logic [15:0] w, input string tag);
      logic [35:0] exp_cmd[$];
      logic [29:0] ca;
      int          rem, b, n;
      rem = int'(w);
      ca  = {a[29:2], 2'b00};
      while (rem > 0) begin
         b = (rem > MAX_BURST) ? MAX_BURST : rem;
         exp_cmd.push_back({6'(b - 1), ca});
         ca  = ca + 30'(4 * b);
         rem = rem - b;
      end
      n = 0;
      while (done_cnt == 0 && n < 20000) begin
         step();
         n++;
      end
      step();
      step();
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_done_with_last"}, done_bad, 0);
      check({tag, "_cmd_count"}, cmd_log.size(), exp_cmd.size());
      for (int i = 0; i < cmd_log.size() && i < exp_cmd.size(); i++)
         check($sformatf("%s_cmd%0d", tag, i), cmd_log[i], exp_cmd[i]);
      check({tag, "_beat_count"}, beat_log.size(), w);
      for (int i = 0; i < beat_log.size() && i < int'(w); i++)
         check($sformatf("%s_beat%0d", tag, i), beat_log[i],
               {(i == int'(w) - 1), mem_word({a[29:2], 2'b00} + 30'(4 * i))});
      check({tag, "_pop_empty"}, viol_empty, 0);
      check({tag, "_stable"}, viol_stable, 0);
      check({tag, "_fifo_bound"}, (max_fifo <= DEPTH), 1);
   endtask

   initial begin
      logic [29:0] ra;
      logic [15:0] rw;
      int          n;
      salt                  = $urandom;
      bus.c3_calib_done     = 1'b0;
      bus.req_valid         = 1'b0;
      bus.req_addr          = 30'd0;
      bus.req_words         = 16'd0;
      bus.c3_p2_rd_overflow = 1'b0;
      bus.c3_p2_rd_error    = 1'b0;
      bus.c3_p2_cmd_full    = 1'b0;
      bus.m_ready           = 1'b0;
      bus.c3_p2_rd_empty    = 1'b1;
      bus.c3_p2_rd_data     = 32'd0;

      #1 rst_n = 1'b0;
      #1 check_outputs_zero("reset0");
      step();
      step();
      rst_n = 1'b1;
      step();
      step();
      check("calib_wait_ready", bus.req_ready, 0);
      bus.c3_calib_done = 1'b1;
      step();
      check("calib_done_ready", bus.req_ready, 1);

      // Unaligned single word.
      start_xfer(30'h103, 16'd1);
      finish_xfer(30'h103, 16'd1, "single");

      // Three bursts at full rate.
      start_xfer(30'h0, 16'd130);
      finish_xfer(30'h0, 16'd130, "b130");

      // Consumer stalls after the first beat: no second command may fit in the FIFO.
      start_xfer(30'h1000, 16'd200);
      n = 0;
      while (beat_log.size() == 0 && n < 1000) begin
         step();
         n++;
      end
      hold_ready = 1'b1;
      repeat (120) step();
      check("stall_cmd_count", cmd_log.size(), 1);
      check("stall_fifo_bound", (max_fifo <= DEPTH), 1);
      hold_ready = 1'b0;
      finish_xfer(30'h1000, 16'd200, "stall");

      // Command FIFO full for the first five ISSUE cycles.
      full_force = 1'b1;
      start_xfer(30'h2000, 16'd100);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("full%0d_cmd_en", i), bus.c3_p2_cmd_en, 0);
         check($sformatf("full%0d_instr", i), bus.c3_p2_cmd_instr, 3'b001);
         check($sformatf("full%0d_bl", i), bus.c3_p2_cmd_bl, 6'd63);
         check($sformatf("full%0d_addr", i), bus.c3_p2_cmd_byte_addr, 30'h2000);
         if (i < 4) step();
      end
      full_force = 1'b0;
      step();
      check("full_release_cmd_en", bus.c3_p2_cmd_en, 1);
      finish_xfer(30'h2000, 16'd100, "full");

      // Zero-length request.
      zero_mode = 1'b1;
      start_xfer(30'h40, 16'd0);
      check("zero_done", bus.done, 1);
      check("zero_ready", bus.req_ready, 1);
      step();
      check("zero_done_once", bus.done, 0);
      step();
      check("zero_cmds", cmd_log.size(), 0);
      check("zero_beats", beat_log.size(), 0);
      check("zero_done_cnt", done_cnt, 1);
      zero_mode = 1'b0;

      // rd_error mid-transfer sets a sticky err; the transfer still completes.
      ready_pct = 70;
      empty_pct = 20;
      start_xfer(30'h3000, 16'd150);
      repeat (20) step();
      bus.c3_p2_rd_error = 1'b1;
      step();
      bus.c3_p2_rd_error = 1'b0;
      step();
      check("err_set", bus.err, 1);
      finish_xfer(30'h3000, 16'd150, "errx");
      check("err_held", bus.err, 1);
      start_xfer(30'h3800, 16'd10);
      check("err_cleared", bus.err, 0);
      repeat (3) step();
      bus.c3_p2_rd_overflow = 1'b1;
      step();
      bus.c3_p2_rd_overflow = 1'b0;
      step();
      check("ovf_err_set", bus.err, 1);
      finish_xfer(30'h3800, 16'd10, "ovfx");

      // Randomized transfers, one straddling the 2^30 address wrap.
      for (int t = 0; t < 6; t++) begin
         ra        = (t == 0) ? 30'h3FFF_FF80 : 30'($urandom);
         rw        = 16'($urandom_range(260, 1));
         ready_pct = int'($urandom_range(100, 30));
         empty_pct = int'($urandom_range(40, 0));
         full_pct  = int'($urandom_range(40, 0));
         start_xfer(ra, rw);
         finish_xfer(ra, rw, $sformatf("rnd%0d", t));
      end
      ready_pct = 100;
      empty_pct = 0;
      full_pct  = 0;

      // Reset in the middle of a burst, away from any clock edge.
      start_xfer(30'h5000, 16'd200);
      repeat (30) step();
      #2;
      rst_n             = 1'b0;
      bus.c3_calib_done = 1'b0;
      #1 check_outputs_zero("midrst");
      step();
      step();
      rst_n = 1'b1;
      repeat (3) step();
      check("midrst_no_calib_ready", bus.req_ready, 0);
      bus.c3_calib_done = 1'b1;
      step();
      check("midrst_calib_ready", bus.req_ready, 1);
      start_xfer(30'h6004, 16'd70);
      finish_xfer(30'h6004, 16'd70, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
